// File: rtl/div_pkg.sv
// Shared types and helpers for the divider issue/control stage.
package div_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Pick quotient or remainder from {rem, quo}. W ops sign-extend bit 31,
    // and that includes the unsigned W variants.
    function automatic logic [XLEN-1:0] div_select(input logic [2*XLEN-1:0] res,
                                                   input logic             is_rem,
                                                   input logic             word);
        logic [XLEN-1:0] sel;
        sel = is_rem ? res[2*XLEN-1:XLEN] : res[XLEN-1:0];
        return word ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
    endfunction

endpackage

// File: rtl/div_result_cache.sv
// Single-entry cache of the last completed divide: operands, flags and the
// full {rem, quo} result, so a DIV/REM pair on the same operands divides once.
module div_result_cache
    import div_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [XLEN-1:0]   wr_rs1,
    input  logic [XLEN-1:0]   wr_rs2,
    input  logic              wr_unsigned,
    input  logic              wr_word,
    input  logic [2*XLEN-1:0] wr_result,
    input  logic [XLEN-1:0]   lk_rs1,
    input  logic [XLEN-1:0]   lk_rs2,
    input  logic              lk_unsigned,
    input  logic              lk_word,
    output logic              hit,
    output logic [2*XLEN-1:0] hit_result
);

    logic              vld_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   rs2_q;
    logic              uns_q;
    logic              word_q;
    logic [2*XLEN-1:0] res_q;

    // Entry storage; only reset clears the valid bit, flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            uns_q  <= 1'b0;
            word_q <= 1'b0;
            res_q  <= '0;
        end else if (wr_en) begin
            vld_q  <= 1'b1;
            rs1_q  <= wr_rs1;
            rs2_q  <= wr_rs2;
            uns_q  <= wr_unsigned;
            word_q <= wr_word;
            res_q  <= wr_result;
        end
    end

    // Full tag compare; the REM/DIV choice is not part of the tag.
    always_comb begin
        hit        = vld_q && (rs1_q == lk_rs1) && (rs2_q == lk_rs2) &&
                     (uns_q == lk_unsigned) && (word_q == lk_word);
        hit_result = res_q;
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/sequencing control in front of the multi-cycle divider.
// Optional feature macro: DIV_RESULT_CACHE_EN (last-result cache, IDLE->DONE on hit).
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_rem,
    input  logic              in_unsigned,
    input  logic              in_word,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              div_valid,
    output logic              div_sign,
    output logic              div_32,
    output logic [XLEN-1:0]   div_rs1,
    output logic [XLEN-1:0]   div_rs2,
    input  logic              div_ready,
    input  logic [2*XLEN-1:0] div_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    div_state_e state, state_nxt;
    logic       is_rem_q;
    logic       accept;
    logic       finish;
    logic       cache_hit;
    logic [XLEN-1:0] hit_data;

    assign accept = (state == IDLE) && in_valid && !flush;
    // A flush coinciding with div_ready throws the result away.
    assign finish = (state == BUSY) && div_ready && !flush;

`ifdef DIV_RESULT_CACHE_EN
    logic [2*XLEN-1:0] cache_result;

    div_result_cache u_cache (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (finish),
        .wr_rs1      (div_rs1),
        .wr_rs2      (div_rs2),
        .wr_unsigned (!div_sign),
        .wr_word     (div_32),
        .wr_result   (div_result),
        .lk_rs1      (in_rs1),
        .lk_rs2      (in_rs2),
        .lk_unsigned (in_unsigned),
        .lk_word     (in_word),
        .hit         (cache_hit),
        .hit_result  (cache_result)
    );

    assign hit_data = div_select(cache_result, in_is_rem, in_word);
`else
    assign cache_hit = 1'b0;
    assign hit_data  = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and state-decoded outputs; flush overrides everything.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        div_valid = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_nxt = cache_hit ? DONE : BUSY;
            end
            BUSY: begin
                div_valid = 1'b1;
                if (div_ready) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Operand/flag capture on accept; held constant while the divider runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_rs1  <= '0;
            div_rs2  <= '0;
            div_sign <= 1'b0;
            div_32   <= 1'b0;
            is_rem_q <= 1'b0;
            out_tag  <= '0;
        end else if (accept) begin
            div_rs1  <= in_rs1;
            div_rs2  <= in_rs2;
            div_sign <= !in_unsigned;
            div_32   <= in_word;
            is_rem_q <= in_is_rem;
            out_tag  <= in_tag;
        end
    end

    // Result register: loaded from the cache on a hit or from the divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  out_data <= '0;
        else if (accept && cache_hit) out_data <= hit_data;
        else if (finish)             out_data <= div_select(div_result, is_rem_q, div_32);
    end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Control and sequencing stage in front of the multi-cycle non-restoring divider in the EX stage. Accepts one RISC-V M-extension divide/remainder operation at a time from the issue path (DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW). It drives and holds the divider's request, waits for its ready, then selects quotient or remainder from the 128-bit result and sign-extends W results. The final 64-bit value goes to writeback through a valid/ready handshake.

## Interface
- TAG_W, 5, width of the destination-register tag carried alongside the op
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous and active-low
- in_valid  in  1  operation offered
- in_ready  out  1  block accepts the operation this cycle
- in_is_rem / in_unsigned / in_word  in  1 each  REM vs DIV, unsigned vs signed, 32-bit W variant
- in_rs1, in_rs2  in  64 each  dividend, divisor
- in_tag  in  TAG_W  destination tag
- flush  in  1  kill in-flight operation
- div_valid  out  1  divider request, held high for the whole computation
- div_sign, div_32  out  1 each  signed = ~unsigned; word mode
- div_rs1, div_rs2  out  64 each  registered operands
- div_ready  in  1  divider result valid, combinational from divider
- div_result  in  128  {remainder[127:64], quotient[63:0]}; W results sit in bits [31:0] of each half
- out_valid  out  1  result available
- out_ready  in  1  writeback consumes
- out_data  out  64  final result
- out_tag  out  TAG_W  tag of result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - in_valid & ~flush captures rs1, rs2, flags and tag, and moves to BUSY.
- BUSY:
  - div_valid = 1, with operands and flags held constant.
  - div_ready = 1 captures the selected, extended result into the out_data register and moves to DONE.
- DONE:
  - out_valid = 1, with out_data and out_tag stable.
  - out_valid & out_ready moves to IDLE.
  - Back-to-back acceptance is not allowed: in_ready is 0 in DONE.
- Result select:
  - sel = in_is_rem ? div_result[127:64] : div_result[63:0].
  - Word mode: out_data = {{32{sel[31]}}, sel[31:0]}. This applies to unsigned W ops too.
- div_valid is registered (state == BUSY). It is 0 in the cycle after div_ready, so the divider's counter returns to 0 and does not restart.
- Divide-by-zero and overflow are handled inside the divider: ready arrives in the first BUSY cycle and the result is used unchanged.
- Flush, in any state:
  - Next state is IDLE.
  - div_valid and out_valid are 0 from the next cycle.
  - A flush in the same cycle as in_valid blocks acceptance.
  - A flush in the same cycle as div_ready discards the result.
- Reset, including mid-operation:
  - State = IDLE; div_valid, out_valid, busy = 0.
  - out_data, out_tag, div_rs1, div_rs2 = 0.
  - div_sign, div_32 = 0.
  - The cache-valid flag is cleared.

## Timing
- Accept at edge 0; div_valid is high from cycle 1.
- Normal op: div_ready comes on the 67th div_valid cycle. out_valid rises the cycle after. Total is 68 cycles from accept to out_valid.
- Special case (zero or overflow): out_valid 2 cycles after accept.
- Cache hit: out_valid 1 cycle after accept.
- out_valid stays high until out_ready. There is no combinational path from out_ready to in_ready.

## Configuration
- DIV_RESULT_CACHE_EN, when defined:
  - Keeps the last completed, non-flushed {rs1, rs2, unsigned, word, 128-bit result} plus a valid bit.
  - A new op whose operands and flags match takes IDLE→DONE directly, with no div_valid. Its half is selected from the cached result.
  - This serves DIV followed by REM on the same operands.
  - Reset clears the valid bit; flush does not.
- Undefined: every op goes through BUSY, and no cache storage exists.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE/BUSY/DONE)
  - XLEN = 64
  - the result-select / sign-extend function shared with the bench model
- One sub-module, div_result_cache: tag compare plus result storage, instantiated only under DIV_RESULT_CACHE_EN.

## Test plan
- DIV rs1=20, rs2=-3 → out_data = -6 (0xFFFFFFFFFFFFFFFA) after 68 cycles; REM same operands → 2.
- REMU rs1=7, rs2=0 → 7, out_valid 2 cycles after accept; DIVU 7/0 → 0xFFFFFFFFFFFFFFFF.
- DIVW rs1=0x80000000, rs2=0xFFFFFFFF → 0xFFFFFFFF80000000; DIVUW 0xFFFFFFFE/1 → 0xFFFFFFFFFFFFFFFE.
- out_ready held low 5 cycles in DONE → out_data and out_tag stable, in_ready = 0, div_valid = 0 throughout.
- flush at cycle 30 of BUSY → div_valid = 0 next cycle, no out_valid. A following DIV 100/7 → 14. rst_n pulsed mid-BUSY → all outputs 0 immediately.
- With DIV_RESULT_CACHE_EN: DIV 100/7 then REM 100/7 → second returns 2 one cycle after accept with div_valid never asserted. Without the macro → 68 cycles.
